fwd_hazard_scoreboard: RTL
==========================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the ARM pipeline.
- Keeps a shift-register scoreboard of in-flight destination tags: the EXE stage plus FWD_DEPTH downstream stages.
- Drives the per-operand forward-select for the instruction in EXE.
- Raises a load-use stall for the instruction in ID and counts stall cycles.
- Sits between ID/EXE control and the EXE operand muxes.

Parameters:
REG_ADDR_W, 4, register address width
NUM_SRC, 2, source operands per instruction
FWD_DEPTH, 2, downstream stages that can forward (stage 1 = MEM, stage 2 = WB, ...)
LOAD_LAT, 1, load data becomes forwardable only from stage LOAD_LAT+1 onward
SEL_W, $clog2(FWD_DEPTH+1), width of each select field
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
Forwarding_EN  in  1  1 = forwarding enabled
freeze  in  1  global pipeline hold (memory wait); nothing advances
flush  in  1  branch taken; kill the ID instruction
id_src  in  NUM_SRC*REG_ADDR_W  source registers of the ID instruction; field i = bits [i*REG_ADDR_W +: REG_ADDR_W]
id_src_vld  in  NUM_SRC  per-source "operand is read"
id_dest  in  REG_ADDR_W  destination of the ID instruction
id_wb_en  in  1  ID instruction writes a register
id_is_load  in  1  ID instruction is a load
Sel_src  out  NUM_SRC*SEL_W  per-operand select for the EXE instruction: 0 = register file, k = forward from stage k
hazard_stall  out  1  hold PC and IF/ID, insert bubble into EXE
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
Scoreboard state:
- Entry k (0 = EXE, 1..FWD_DEPTH) holds {vld, wb_en, dest, is_load}.
- The EXE source registers and their valid bits are held in a separate register.
- Reset: all entries and the EXE sources are cleared (vld = 0). Sel_src = 0, hazard_stall = 0, stall_cnt = 0.

Advance, at each rising clk edge when freeze = 0:
- Entry k+1 <= entry k for k = 0..FWD_DEPTH-1. Entry FWD_DEPTH is dropped.
- Entry 0 and the EXE sources load from the ID inputs, unless flush = 1 or hazard_stall = 1. In either of those cases a bubble is inserted (vld = 0, srcs invalid).

Freeze:
- freeze = 1 holds all state, including stall_cnt.
- flush together with freeze: flush is ignored. The branch unit re-asserts flush after the freeze.

Match rule:
- Entry k matches source s when vld, wb_en, src_vld[s] and dest == src[s] are all true.

Forwarding select (combinational from registered state):
- Forwarding_EN = 0 -> every select field = 0.
- Otherwise, field s = the smallest k in 1..FWD_DEPTH whose entry matches EXE source s and is forwardable; 0 if none.
- Forwardable means is_load = 0, or k >= LOAD_LAT+1.
- The youngest producer always wins.

hazard_stall (combinational):
- Considers ID sources against entries 0..FWD_DEPTH-1 only; entries at stage FWD_DEPTH write the register file this cycle (write-before-read).
- Forwarding_EN = 1: assert if any ID source matches entry k with is_load = 1 and k+1 < LOAD_LAT+1. Such a load is not yet forwardable when the ID instruction reaches EXE.
- Forwarding_EN = 0: assert if any ID source matches any valid, writing entry 0..FWD_DEPTH-1.
- Forced to 0 when flush = 1, because the ID instruction is dead.
- A stall repeats each cycle until the producer advances far enough. Example: LOAD_LAT = 2 gives a 2-cycle stall for an immediately dependent use.

stall_cnt:
- Increments on each edge where hazard_stall = 1 and freeze = 0.
- Saturates at all ones.

Widths:
- Select values are at most FWD_DEPTH and fit in SEL_W.
- Register r0 gets no special treatment; every address forwards.

Test Plan:
- Defaults: ADD r1 in ID then SUB r2, r1, r3 -> next cycle SUB in EXE, Sel_src field 0 = 1; one cycle later with no new producer, field shows 2 if re-read; hazard_stall stays 0.
- LDR r4 then ADD r5, r4, r4 (defaults) -> hazard_stall = 1 for exactly 1 cycle and stall_cnt = 1; after the bubble, ADD in EXE gets both fields = 2.
- LOAD_LAT = 2, FWD_DEPTH = 3, LDR r4 then dependent use -> hazard_stall high 2 cycles, then field = 3.
- Forwarding_EN = 0: ADD r1 then use of r1 -> stall 2 cycles with FWD_DEPTH = 2 and Sel_src = 0 throughout.
- ADD r1 at stage 2 and ADD r1 at stage 1, both matching -> select = 1 (youngest). Assert freeze for 3 cycles mid-stall -> state and stall_cnt unchanged.
- Load-use stall condition present with flush = 1 -> hazard_stall = 0 and bubble in EXE. Assert rst mid-operation -> all outputs 0 immediately, without waiting for a clk edge. Force stall_cnt to all ones and stall once more -> value holds at 0xFFFF.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit.
// A shift-register scoreboard tracks destination tags from EXE down through
// FWD_DEPTH forwarding stages. The EXE operand selects and the ID-stage stall
// are derived combinationally from that registered state.
module fwd_hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Forwarding_EN,
  input  logic                          freeze,
  input  logic                          flush,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_vld,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_is_load,
  output logic [NUM_SRC*SEL_W-1:0]      Sel_src,
  output logic                          hazard_stall,
  output logic [CNT_W-1:0]              stall_cnt
);

  // Scoreboard entries: index 0 is EXE, index k is k stages downstream.
  logic [FWD_DEPTH:0]                 ent_vld_q, ent_vld_d;
  logic [FWD_DEPTH:0]                 ent_wb_q, ent_wb_d;
  logic [FWD_DEPTH:0]                 ent_ld_q, ent_ld_d;
  logic [FWD_DEPTH:0][REG_ADDR_W-1:0] ent_dest_q, ent_dest_d;

  // Source operands of the instruction currently in EXE.
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] exe_src_q, exe_src_d;
  logic [NUM_SRC-1:0]                 exe_src_vld_q, exe_src_vld_d;

  logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;

  // Saturating increment: the counter sticks at all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Operand select for the EXE instruction: youngest forwardable producer wins.
  always_comb begin
    Sel_src = '0;
    if (Forwarding_EN) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        // Walk oldest to youngest so the youngest match overwrites older ones.
        for (int k = FWD_DEPTH; k >= 1; k--) begin
          if (ent_vld_q[k] && ent_wb_q[k] && exe_src_vld_q[s] &&
              (ent_dest_q[k] == exe_src_q[s]) &&
              (!ent_ld_q[k] || (k >= LOAD_LAT + 1))) begin
            Sel_src[s*SEL_W +: SEL_W] = SEL_W'(k);
          end
        end
      end
    end
  end

  // Load-use / no-forwarding stall for the ID instruction. The last stage is
  // excluded because it writes the register file in the same cycle ID reads it.
  always_comb begin
    hazard_stall = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (id_src_vld[s] && ent_vld_q[k] && ent_wb_q[k] &&
            (ent_dest_q[k] == id_src[s*REG_ADDR_W +: REG_ADDR_W])) begin
          if (!Forwarding_EN) begin
            hazard_stall = 1'b1;
          end else if (ent_ld_q[k] && (k + 1 < LOAD_LAT + 1)) begin
            // Load data not yet forwardable when the consumer reaches EXE.
            hazard_stall = 1'b1;
          end
        end
      end
    end
    // A flushed ID instruction is dead and must not hold the front end.
    if (flush) hazard_stall = 1'b0;
  end

  // Next-state: shift the scoreboard, load or bubble EXE, count stalls.
  always_comb begin
    ent_vld_d     = ent_vld_q;
    ent_wb_d      = ent_wb_q;
    ent_ld_d      = ent_ld_q;
    ent_dest_d    = ent_dest_q;
    exe_src_d     = exe_src_q;
    exe_src_vld_d = exe_src_vld_q;
    stall_cnt_d   = stall_cnt_q;
    if (!freeze) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        ent_vld_d[k]  = ent_vld_q[k-1];
        ent_wb_d[k]   = ent_wb_q[k-1];
        ent_ld_d[k]   = ent_ld_q[k-1];
        ent_dest_d[k] = ent_dest_q[k-1];
      end
      if (flush || hazard_stall) begin
        ent_vld_d[0]  = 1'b0;
        ent_wb_d[0]   = 1'b0;
        ent_ld_d[0]   = 1'b0;
        ent_dest_d[0] = '0;
        exe_src_d     = '0;
        exe_src_vld_d = '0;
      end else begin
        ent_vld_d[0]  = 1'b1;
        ent_wb_d[0]   = id_wb_en;
        ent_ld_d[0]   = id_is_load;
        ent_dest_d[0] = id_dest;
        for (int s = 0; s < NUM_SRC; s++) begin
          exe_src_d[s] = id_src[s*REG_ADDR_W +: REG_ADDR_W];
        end
        exe_src_vld_d = id_src_vld;
      end
      if (hazard_stall) stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld_q     <= '0;
      ent_wb_q      <= '0;
      ent_ld_q      <= '0;
      ent_dest_q    <= '0;
      exe_src_q     <= '0;
      exe_src_vld_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ent_vld_q     <= ent_vld_d;
      ent_wb_q      <= ent_wb_d;
      ent_ld_q      <= ent_ld_d;
      ent_dest_q    <= ent_dest_d;
      exe_src_q     <= exe_src_d;
      exe_src_vld_q <= exe_src_vld_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
